// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake dataflow units.
package handshake_pkg;

  // Smallest storage depth any handshake buffer may be built with.
  localparam int HS_MIN_SLOTS = 1;

  // Ceiling log2, never below 1 so a single-entry structure still gets a 1-bit index.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed slot; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic FIFO between valid/ready channels; both ready and valid are driven
// from registered flags only, so no combinational path crosses the buffer.
module handshake_elastic_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int DEPTH = (NUM_SLOTS < HS_MIN_SLOTS) ? HS_MIN_SLOTS : NUM_SLOTS;
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             empty_q;
  logic             full_q;
  logic             push;
  logic             pop;

  // Ready/valid are gated by reset so nothing transfers while reset is held.
  assign ins_ready  = !full_q && rst;
  assign outs_valid = !empty_q && rst;
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;

  handshake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (ins),
    .rd_addr (rd_ptr),
    .rd_data (outs)
  );

  // Occupancy after this cycle's transfers; a simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (pop && !push) count_nxt = count - CNT_W'(1);
  end

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work; flags are
  // registered from the next occupancy so they are valid at cycle start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == FULL_CNT);
    end
  end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo: a 37-bit x 4 instance and an 8-bit x 3
// instance, each compared every cycle against a queue-based reference.
module tb_handshake_elastic_fifo;

  localparam int AW = 37;
  localparam int AN = 4;
  localparam int BW = 8;
  localparam int BN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_ins_valid, a_ins_ready, a_outs_valid, a_outs_ready;
  logic [AW-1:0] a_ins, a_outs;
  logic          b_rst, b_ins_valid, b_ins_ready, b_outs_valid, b_outs_ready;
  logic [BW-1:0] b_ins, b_outs;

  handshake_elastic_fifo #(.DATA_WIDTH(AW), .NUM_SLOTS(AN)) dut_a (
    .clk(clk), .rst(a_rst), .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready));

  handshake_elastic_fifo #(.DATA_WIDTH(BW), .NUM_SLOTS(BN)) dut_b (
    .clk(clk), .rst(b_rst), .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready));

  int total = 0;
  int bad   = 0;

  // Reference contents of each FIFO, head at index 0.
  logic [AW-1:0] qa[$];
  logic [BW-1:0] qb[$];
  logic [BW-1:0] b_delivered[$];
  int            a_pushed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_a_ready(); return a_rst && (qa.size() < AN); endfunction
  function automatic logic exp_a_valid(); return a_rst && (qa.size() > 0);  endfunction
  function automatic logic exp_b_ready(); return b_rst && (qb.size() < BN); endfunction
  function automatic logic exp_b_valid(); return b_rst && (qb.size() > 0);  endfunction

  task automatic check_outputs(input string sfx);
    chk({"a_ins_ready", sfx},  {63'd0, a_ins_ready},  {63'd0, exp_a_ready()});
    chk({"a_outs_valid", sfx}, {63'd0, a_outs_valid}, {63'd0, exp_a_valid()});
    chk({"b_ins_ready", sfx},  {63'd0, b_ins_ready},  {63'd0, exp_b_ready()});
    chk({"b_outs_valid", sfx}, {63'd0, b_outs_valid}, {63'd0, exp_b_valid()});
  endtask

  // One clock cycle: inputs are already driven by the caller at the falling edge.
  task automatic step();
    logic ra, va, rb, vb;
    // Changing the inputs must not move ready/valid within the cycle.
    #1;
    check_outputs("_comb");
    ra = exp_a_ready(); va = exp_a_valid();
    rb = exp_b_ready(); vb = exp_b_valid();
    @(posedge clk);
    if (!a_rst) qa.delete();
    else begin
      if (va && a_outs_ready) void'(qa.pop_front());
      if (ra && a_ins_valid) begin qa.push_back(a_ins); a_pushed++; end
    end
    if (!b_rst) qb.delete();
    else begin
      if (vb && b_outs_ready) b_delivered.push_back(qb.pop_front());
      if (rb && b_ins_valid) qb.push_back(b_ins);
    end
    @(negedge clk);
    check_outputs("");
    if (exp_a_valid()) chk("a_outs", {27'd0, a_outs}, {27'd0, qa[0]});
    if (exp_b_valid()) chk("b_outs", {56'd0, b_outs}, {56'd0, qb[0]});
  endtask

  task automatic a_drive(input logic v, input logic [AW-1:0] d, input logic r);
    a_ins_valid = v; a_ins = d; a_outs_ready = r;
  endtask

  task automatic b_drive(input logic v, input logic [BW-1:0] d, input logic r);
    b_ins_valid = v; b_ins = d; b_outs_ready = r;
  endtask

  initial begin
    a_pushed = 0;
    a_rst = 1'b0; b_rst = 1'b0;
    a_drive(1'b0, '0, 1'b0);
    b_drive(1'b0, '0, 1'b0);
    @(negedge clk);

    // Reset held for two cycles, then idle.
    repeat (2) step();
    a_rst = 1'b1; b_rst = 1'b1;
    step();
    chk("t1_ready_after_rel", {63'd0, a_ins_ready}, 64'd1);
    chk("t1_valid_after_rel", {63'd0, a_outs_valid}, 64'd0);

    // Single token with an always-ready consumer.
    a_drive(1'b1, 37'h0E0F7D1A4C, 1'b1);
    step();
    chk("t2_outs", {27'd0, a_outs}, 64'h0E0F7D1A4C);
    a_drive(1'b0, '0, 1'b1);
    step();
    chk("t2_valid_gone", {63'd0, a_outs_valid}, 64'd0);

    // Fill with the consumer stalled, then drain.
    for (int i = 1; i <= 4; i++) begin
      a_drive(1'b1, AW'(i), 1'b0);
      step();
    end
    chk("t3_full", {63'd0, a_ins_ready}, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain", {27'd0, a_outs}, 64'(i));
      a_drive(1'b0, '0, 1'b1);
      step();
      if (i == 1) chk("t3_ready_rise", {63'd0, a_ins_ready}, 64'd1);
    end

    // Continuous streaming through the 3-slot instance exercises pointer wrap.
    for (int i = 0; i < 10; i++) begin
      b_drive(1'b1, BW'(i), 1'b1);
      step();
    end
    b_drive(1'b0, '0, 1'b1);
    repeat (3) step();
    chk("t4_count", 64'(b_delivered.size()), 64'd10);
    for (int i = 0; i < 10 && i < b_delivered.size(); i++)
      chk("t4_order", {56'd0, b_delivered[i]}, 64'(i));

    // Reset with three tokens stored; none may reappear.
    for (int i = 0; i < 3; i++) begin
      b_drive(1'b1, BW'(8'h50 + i), 1'b0);
      step();
    end
    b_drive(1'b0, '0, 1'b0);
    b_rst = 1'b0;
    step();
    b_rst = 1'b1;
    step();
    chk("t5_empty_after_rst", {63'd0, b_outs_valid}, 64'd0);
    b_drive(1'b1, 8'hAA, 1'b0);
    step();
    chk("t5_first_token", {56'd0, b_outs}, 64'hAA);
    b_drive(1'b0, '0, 1'b1);
    step();
    chk("t5_drained", {63'd0, b_outs_valid}, 64'd0);

    // Random valid and backpressure on both instances.
    a_pushed = 0;
    for (int cyc = 0; cyc < 20000 && a_pushed < 1000; cyc++) begin
      a_drive(1'($urandom_range(0, 1)), {5'($urandom), $urandom}, 1'($urandom_range(0, 1)));
      b_drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      step();
    end
    chk("t6_tokens_pushed", 64'(a_pushed >= 1000), 64'd1);
    a_drive(1'b0, '0, 1'b1);
    b_drive(1'b0, '0, 1'b1);
    repeat (6) step();
    chk("t6_a_drained", {63'd0, a_outs_valid}, 64'd0);
    chk("t6_b_drained", {63'd0, b_outs_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
